exhaust_ctrl_gen: RTL and testbench

Parametrised range-hood exhaust controller, next generation of the fixed three-level fan FSM. It supports NUM_LEVELS fan levels, where the top level is the timed "boost" (hurricane) level. Boost and forced-return countdowns have parameterised lengths. Boost is limited to once per power-on session. The whole block runs in the single clk domain with a 1 Hz enable pulse, with no second clock. It sits between the key debouncer/edge-detector and the fan driver and 7-segment display logic.

---
 rtl/exhaust_ctrl_gen_pkg.sv | 7 +
 rtl/exhaust_ctrl_gen_if.sv | 21 ++
 rtl/exhaust_ctrl_gen_countdown.sv | 18 +
 rtl/exhaust_ctrl_gen.sv | 93 +++++++++
 tb/tb_exhaust_ctrl_gen.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/exhaust_ctrl_gen_pkg.sv
// exhaust_pkg: shared state encoding and level-width helper for the exhaust controller
package exhaust_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_SELECT, ST_RUN, ST_BOOST, ST_RETURN} state_t;
    function automatic int lvl_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/exhaust_ctrl_gen_if.sv
// exhaust_ctrl_gen_if: key/tick inputs and fan/display outputs of the exhaust controller
interface exhaust_ctrl_gen_if import exhaust_pkg::*; #(
    parameter int NUM_LEVELS = 3,
    parameter int CNT_W      = 8
);
    logic                           tick;
    logic                           power_on;
    logic                           menu_key;
    logic [NUM_LEVELS-1:0]          level_key;
    logic [lvl_w(NUM_LEVELS)-1:0]   level;
    logic                           busy;
    logic [CNT_W-1:0]               countdown;
    logic                           countdown_active;
    logic                           in_select;
    logic                           boost_used;
    logic                           boost_denied;
    modport master(output tick, power_on, menu_key, level_key,
                   input level, busy, countdown, countdown_active, in_select, boost_used, boost_denied);
    modport slave(input tick, power_on, menu_key, level_key,
                  output level, busy, countdown, countdown_active, in_select, boost_used, boost_denied);
endinterface

// File: rtl/exhaust_ctrl_gen_countdown.sv
// exhaust_countdown: saturating down-counter, load beats tick
module exhaust_countdown #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             zero
);
    always_ff @(posedge clk or posedge rst)
        if (rst) value <= '0;
        else if (load) value <= load_val;
        else if (en && !zero) value <= value - CNT_W'(1);
    assign zero = value == '0;
endmodule

// File: rtl/exhaust_ctrl_gen.sv
// exhaust_ctrl_gen: range-hood fan FSM with timed once-per-session boost and forced return
module exhaust_ctrl_gen import exhaust_pkg::*; #(
    parameter int NUM_LEVELS  = 3,
    parameter int BOOST_SECS  = 60,
    parameter int RETURN_SECS = 60,
    parameter int CNT_W       = 8
) (
    input logic              clk,
    input logic              rst,
    exhaust_ctrl_gen_if.slave bus
);
    localparam int LW = lvl_w(NUM_LEVELS);
    state_t           st, st_n;
    logic [LW-1:0]    lvl, lvl_n;
    logic             used, used_n, den, den_n, load, zero;
    logic [CNT_W-1:0] load_val, cnt;
    int               sel;
    exhaust_countdown #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .en       (bus.tick && (st == ST_BOOST || st == ST_RETURN)),
        .load_val (load_val),
        .value    (cnt),
        .zero     (zero)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st   <= ST_IDLE;
            lvl  <= '0;
            used <= 1'b0;
            den  <= 1'b0;
        end else begin
            st   <= st_n;
            lvl  <= lvl_n;
            used <= used_n;
            den  <= den_n;
        end
    always_comb begin
        st_n     = st;
        lvl_n    = lvl;
        used_n   = used;
        den_n    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        sel      = 0;
        for (int i = NUM_LEVELS - 1; i >= 0; i--) if (bus.level_key[i]) sel = i;
        if (!bus.power_on) begin
            st_n   = ST_IDLE;
            lvl_n  = '0;
            used_n = 1'b0;
            load   = 1'b1;
        end else case (st)
            ST_IDLE: if (bus.menu_key) st_n = ST_SELECT;
            ST_SELECT, ST_RUN:
                if (bus.menu_key) st_n = ST_IDLE;
                else if (|bus.level_key && !(st == ST_RUN && LW'(sel + 1) == lvl)) begin
                    if (sel == NUM_LEVELS - 1) begin
                        if (used) den_n = 1'b1;
                        else begin
                            st_n     = ST_BOOST;
                            used_n   = 1'b1;
                            load     = 1'b1;
                            load_val = CNT_W'(BOOST_SECS);
                        end
                    end else begin
                        st_n  = ST_RUN;
                        lvl_n = LW'(sel + 1);
                    end
                end
            ST_BOOST:
                if (bus.menu_key) begin
                    st_n     = ST_RETURN;
                    load     = 1'b1;
                    load_val = CNT_W'(RETURN_SECS);
                end else if (zero) begin
                    st_n  = ST_RUN;
                    lvl_n = LW'(NUM_LEVELS - 1);
                end
            ST_RETURN: if (zero) st_n = ST_IDLE;
            default: st_n = ST_IDLE;
        endcase
    end
    always_comb begin
        bus.level            = st == ST_RUN ? lvl : st == ST_BOOST ? LW'(NUM_LEVELS) : '0;
        bus.busy             = st == ST_RUN || st == ST_BOOST;
        bus.countdown_active = st == ST_BOOST || st == ST_RETURN;
        bus.countdown        = (st == ST_BOOST || st == ST_RETURN) ? cnt : '0;
        bus.in_select        = st == ST_SELECT;
        bus.boost_used       = used;
        bus.boost_denied     = den;
    end
endmodule

// File: tb/tb_exhaust_ctrl_gen.sv
// tb_exhaust_ctrl_gen: table-driven and hand-sequenced checks of exhaust_ctrl_gen at 3 and 5 levels
module tb_exhaust_ctrl_gen;
    logic clk = 1'b0;
    logic rst;
    int compared = 0;
    int mismatched = 0;
    always #5 clk = ~clk;

    exhaust_ctrl_gen_if #(.NUM_LEVELS(3), .CNT_W(8)) bus3();
    exhaust_ctrl_gen_if #(.NUM_LEVELS(5), .CNT_W(8)) bus5();

    exhaust_ctrl_gen #(.NUM_LEVELS(3), .BOOST_SECS(5), .RETURN_SECS(4), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3));
    exhaust_ctrl_gen #(.NUM_LEVELS(5), .BOOST_SECS(2), .RETURN_SECS(4), .CNT_W(8)) dut5 (
        .clk(clk), .rst(rst), .bus(bus5));

    typedef struct packed {
        logic [1:0] lvl;
        logic       busy;
        logic [7:0] cd;
        logic       act;
        logic       sel;
        logic       used;
        logic       den;
    } out_t;

    typedef struct {
        string      name;
        logic       pwr;
        logic       menu;
        logic [2:0] keys;
        logic       tick;
        out_t       exp;
    } vec_t;

    vec_t vecs[$];

    function automatic out_t o(int lvl, bit b, int cd, bit a, bit s, bit u, bit d);
        o = '{2'(lvl), b, 8'(cd), a, s, u, d};
    endfunction

    function automatic out_t got3();
        return '{bus3.level, bus3.busy, bus3.countdown, bus3.countdown_active,
                 bus3.in_select, bus3.boost_used, bus3.boost_denied};
    endfunction

    task automatic add(string n, bit p, bit m, logic [2:0] k, bit t, out_t e);
        vec_t v;
        v.name = n; v.pwr = p; v.menu = m; v.keys = k; v.tick = t; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(string n, out_t e);
        out_t g = got3();
        compared++;
        if (g !== e) begin
            mismatched++;
            $display("FAIL %s: got lvl=%0d busy=%0d cd=%0d act=%0d sel=%0d used=%0d den=%0d, want lvl=%0d busy=%0d cd=%0d act=%0d sel=%0d used=%0d den=%0d",
                     n, g.lvl, g.busy, g.cd, g.act, g.sel, g.used, g.den,
                     e.lvl, e.busy, e.cd, e.act, e.sel, e.used, e.den);
        end
    endtask

    task automatic chk_val(string n, int g, int e);
        compared++;
        if (g != e) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d", n, g, e);
        end
    endtask

    task automatic step3(bit p, bit m, logic [2:0] k, bit t);
        bus3.power_on = p; bus3.menu_key = m; bus3.level_key = k; bus3.tick = t;
        @(posedge clk); #1;
        bus3.menu_key = 1'b0; bus3.level_key = '0; bus3.tick = 1'b0;
    endtask

    task automatic step5(bit p, bit m, logic [4:0] k, bit t);
        bus5.power_on = p; bus5.menu_key = m; bus5.level_key = k; bus5.tick = t;
        @(posedge clk); #1;
        bus5.menu_key = 1'b0; bus5.level_key = '0; bus5.tick = 1'b0;
    endtask

    initial begin
        add("menu_sel",        1, 1, 3'b000, 0, o(0, 0, 0, 0, 1, 0, 0));
        add("boost_in",        1, 0, 3'b100, 0, o(3, 1, 5, 1, 0, 1, 0));
        add("tick4",           1, 0, 3'b000, 1, o(3, 1, 4, 1, 0, 1, 0));
        add("tick3",           1, 0, 3'b000, 1, o(3, 1, 3, 1, 0, 1, 0));
        add("hold3",           1, 0, 3'b000, 0, o(3, 1, 3, 1, 0, 1, 0));
        add("boost_key_ign",   1, 0, 3'b001, 0, o(3, 1, 3, 1, 0, 1, 0));
        add("tick2",           1, 0, 3'b000, 1, o(3, 1, 2, 1, 0, 1, 0));
        add("tick1",           1, 0, 3'b000, 1, o(3, 1, 1, 1, 0, 1, 0));
        add("tick0",           1, 0, 3'b000, 1, o(3, 1, 0, 1, 0, 1, 0));
        add("expire",          1, 0, 3'b000, 0, o(2, 1, 0, 0, 0, 1, 0));
        add("menu_idle",       1, 1, 3'b000, 0, o(0, 0, 0, 0, 0, 1, 0));
        add("menu_sel2",       1, 1, 3'b000, 0, o(0, 0, 0, 0, 1, 1, 0));
        add("denied",          1, 0, 3'b100, 0, o(0, 0, 0, 0, 1, 1, 1));
        add("denied_end",      1, 0, 3'b000, 0, o(0, 0, 0, 0, 1, 1, 0));
        add("run1",            1, 0, 3'b001, 0, o(1, 1, 0, 0, 0, 1, 0));
        add("run2",            1, 0, 3'b010, 0, o(2, 1, 0, 0, 0, 1, 0));
        add("same_lvl",        1, 0, 3'b010, 0, o(2, 1, 0, 0, 0, 1, 0));
        add("menu_beats_key",  1, 1, 3'b001, 0, o(0, 0, 0, 0, 0, 1, 0));
        add("menu_sel3",       1, 1, 3'b000, 0, o(0, 0, 0, 0, 1, 1, 0));
        add("low_bit_wins",    1, 0, 3'b110, 0, o(2, 1, 0, 0, 0, 1, 0));
        add("run_tick",        1, 0, 3'b000, 1, o(2, 1, 0, 0, 0, 1, 0));
        add("to_idle",         1, 1, 3'b000, 0, o(0, 0, 0, 0, 0, 1, 0));
        add("idle_key_ign",    1, 0, 3'b001, 0, o(0, 0, 0, 0, 0, 1, 0));

        bus3.power_on = 1'b0; bus3.menu_key = 1'b0; bus3.level_key = '0; bus3.tick = 1'b0;
        bus5.power_on = 1'b0; bus5.menu_key = 1'b0; bus5.level_key = '0; bus5.tick = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", o(0, 0, 0, 0, 0, 0, 0));
        chk_val("reset5_level", int'(bus5.level), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step3(vecs[i].pwr, vecs[i].menu, vecs[i].keys, vecs[i].tick);
            chk(vecs[i].name, vecs[i].exp);
        end

        // power cycle clears boost_used, then menu+tick in BOOST wins into RETURN
        step3(0, 0, 3'b000, 0); chk("pwr_off", o(0, 0, 0, 0, 0, 0, 0));
        step3(1, 1, 3'b000, 0); chk("repower_sel", o(0, 0, 0, 0, 1, 0, 0));
        step3(1, 0, 3'b100, 0); chk("boost_again", o(3, 1, 5, 1, 0, 1, 0));
        step3(1, 0, 3'b000, 1);
        step3(1, 0, 3'b000, 1); chk("boost_cd3", o(3, 1, 3, 1, 0, 1, 0));
        step3(1, 1, 3'b000, 1); chk("menu_beats_tick", o(0, 0, 4, 1, 0, 1, 0));
        step3(1, 1, 3'b001, 0); chk("return_keys_ign", o(0, 0, 4, 1, 0, 1, 0));
        for (int c = 3; c >= 0; c--) begin
            step3(1, 0, 3'b000, 1);
            chk($sformatf("return_cd%0d", c), o(0, 0, c, 1, 0, 1, 0));
        end
        step3(1, 0, 3'b000, 0); chk("return_done", o(0, 0, 0, 0, 0, 1, 0));

        // power drop mid-RETURN, then boost is accepted again
        step3(0, 0, 3'b000, 0);
        step3(1, 1, 3'b000, 0);
        step3(1, 0, 3'b100, 0);
        step3(1, 1, 3'b000, 0); chk("in_return", o(0, 0, 4, 1, 0, 1, 0));
        step3(0, 0, 3'b000, 0); chk("pwr_drop_return", o(0, 0, 0, 0, 0, 0, 0));
        step3(1, 1, 3'b000, 0);
        step3(1, 0, 3'b100, 0); chk("boost_after_repower", o(3, 1, 5, 1, 0, 1, 0));

        // asynchronous reset mid-BOOST, checked before the next clock edge
        #2 rst = 1'b1;
        #1 chk("async_rst", o(0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        rst = 1'b0;
        step3(1, 0, 3'b000, 0); chk("post_rst_idle", o(0, 0, 0, 0, 0, 0, 0));

        // five-level instance: top key is boost, expiry lands on level 4
        step5(1, 1, 5'b00000, 0); chk_val("l5_select", int'(bus5.in_select), 1);
        step5(1, 0, 5'b10000, 0); chk_val("l5_boost_level", int'(bus5.level), 5);
        chk_val("l5_boost_cd", int'(bus5.countdown), 2);
        step5(1, 0, 5'b00000, 1);
        step5(1, 0, 5'b00000, 1); chk_val("l5_cd0_level", int'(bus5.level), 5);
        step5(1, 0, 5'b00000, 0); chk_val("l5_expire_level", int'(bus5.level), 4);
        chk_val("l5_expire_active", int'(bus5.countdown_active), 0);
        step5(1, 0, 5'b01100, 0); chk_val("l5_low_bit", int'(bus5.level), 3);
        step5(1, 1, 5'b00000, 0);
        step5(1, 1, 5'b00000, 0);
        step5(1, 0, 5'b10000, 0); chk_val("l5_denied", int'(bus5.boost_denied), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
